// File: rtl/encoder_8_3_serializer_pkg.sv
// Shared types and widths for the 8-to-3 encoder serializer.
// Replays every set bit of a request vector as a 3-bit code stream.
package encoder_pkg;

    localparam int IN_W   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {IDLE, EMIT} state_t;

endpackage

// File: rtl/encoder_8_3_serializer_if.sv
// Request-vector input and code-stream output handshakes of the serializer.
// The master side is the producer/consumer pair around the block.
interface encoder_8_3_serializer_if;
    import encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              zero_drop;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code, out_last, zero_drop
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code, out_last, zero_drop
    );

endinterface

// File: rtl/encoder_8_3_serializer_priority.sv
// Combinational priority encoder: picks the lowest (dir=1) or highest (dir=0)
// set bit of mask and reports both its index and a one-hot select.
module priority_encoder_8_3
    import encoder_pkg::*;
(
    input  logic [IN_W-1:0]   mask,
    input  logic              dir,
    output logic [CODE_W-1:0] code,
    output logic [IN_W-1:0]   sel
);

    // Scan towards the winning end so the final hit is the one that sticks.
    always_comb begin
        code = '0;
        sel  = '0;
        if (dir) begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    code = CODE_W'(i);
                    sel  = IN_W'(1) << i;
                end
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (mask[i]) begin
                    code = CODE_W'(i);
                    sel  = IN_W'(1) << i;
                end
            end
        end
    end

endmodule

// File: rtl/encoder_8_3_serializer.sv
// Accepts an 8-bit request vector and emits one 3-bit code per set bit,
// flagging the final code so the next vector can load without a bubble.
module encoder_8_3_serializer
    import encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    encoder_8_3_serializer_if.slave bus
);

    state_t            state;
    state_t            state_next;
    logic [IN_W-1:0]   mask;
    logic [IN_W-1:0]   mask_next;
    logic [IN_W-1:0]   sel;
    logic [IN_W-1:0]   remaining;
    logic [CODE_W-1:0] code;
    logic              zero_drop_q;
    logic              zero_drop_next;
    logic              armed;
    logic              emit;
    logic              out_fire;
    logic              last_fire;
    logic              in_fire;

    priority_encoder_8_3 u_priority (
        .mask (mask),
        .dir  (LSB_FIRST),
        .code (code),
        .sel  (sel)
    );

    // Outputs depend only on registered state; out_ready reaches in_ready alone.
    assign emit           = (state == EMIT);
    assign remaining      = mask & ~sel;
    assign bus.out_valid  = emit;
    assign bus.out_code   = emit ? code : '0;
    assign bus.out_last   = emit && (remaining == '0);
    assign out_fire       = emit && bus.out_ready;
    assign last_fire      = out_fire && (remaining == '0);
    assign bus.in_ready   = armed && (!emit || last_fire);
    assign in_fire        = bus.in_valid && bus.in_ready;
    assign bus.zero_drop  = zero_drop_q;

    // armed keeps in_ready low through reset until the first clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '0;
            zero_drop_q <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state       <= state_next;
            mask        <= mask_next;
            zero_drop_q <= zero_drop_next;
            armed       <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        mask_next      = mask;
        zero_drop_next = 1'b0;

        if (out_fire) begin
            mask_next = remaining;
            if (remaining == '0) begin
                state_next = IDLE;
            end
        end

        // A new vector can only land in IDLE or on the last beat, so it overrides.
        if (in_fire) begin
            if (bus.in_data != '0) begin
                mask_next  = bus.in_data;
                state_next = EMIT;
            end else begin
                mask_next      = '0;
                state_next     = IDLE;
                zero_drop_next = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encoder_8_3_serializer.sv
// Self-checking bench: drives an ascending-order and a descending-order
// instance with identical stimulus and checks both against expected streams.
module tb_encoder_8_3_serializer;
    import encoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic       ov [2];
    logic [2:0] oc [2];
    logic       ol [2];
    logic       ir [2];
    logic       zd [2];

    encoder_8_3_serializer_if bl ();
    encoder_8_3_serializer_if bm ();

    encoder_8_3_serializer #(.LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(bl));
    encoder_8_3_serializer #(.LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(bm));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        bl.in_valid = v; bl.in_data = d; bl.out_ready = r;
        bm.in_valid = v; bm.in_data = d; bm.out_ready = r;
    endtask

    task automatic sample();
        ov[0] = bl.out_valid; oc[0] = bl.out_code; ol[0] = bl.out_last;
        ir[0] = bl.in_ready;  zd[0] = bl.zero_drop;
        ov[1] = bm.out_valid; oc[1] = bm.out_code; ol[1] = bm.out_last;
        ir[1] = bm.in_ready;  zd[1] = bm.zero_drop;
    endtask

    task automatic test_reset();
        drive(1'b1, 8'hFF, 1'b1);
        #2;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid dut%0d: got %b expected 0", d, ov[d]); end
            checks++; if (oc[d] !== 3'd0) begin errors++; $display("[TB] FAIL rst_out_code dut%0d: got %0d expected 0", d, oc[d]); end
            checks++; if (ol[d] !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_last dut%0d: got %b expected 0", d, ol[d]); end
            checks++; if (ir[d] !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready dut%0d: got %b expected 0", d, ir[d]); end
            checks++; if (zd[d] !== 1'b0) begin errors++; $display("[TB] FAIL rst_zero_drop dut%0d: got %b expected 0", d, zd[d]); end
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ir[d] !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready dut%0d: got %b expected 1", d, ir[d]); end
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("[TB] FAIL idle_out_valid dut%0d: got %b expected 0", d, ov[d]); end
            checks++; if (zd[d] !== 1'b0) begin errors++; $display("[TB] FAIL idle_zero_drop dut%0d: got %b expected 0", d, zd[d]); end
        end
    endtask

    task automatic test_pattern();
        int exp_code [2][3] = '{'{2, 5, 7}, '{7, 5, 2}};
        drive(1'b1, 8'b1010_0100, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            #1;
            sample();
            for (int d = 0; d < 2; d++) begin
                checks++; if (ov[d] !== 1'b1) begin errors++; $display("[TB] FAIL pat_valid dut%0d beat%0d: got %b expected 1", d, i, ov[d]); end
                checks++; if (oc[d] !== 3'(exp_code[d][i])) begin errors++; $display("[TB] FAIL pat_code dut%0d beat%0d: got %0d expected %0d", d, i, oc[d], exp_code[d][i]); end
                checks++; if (ol[d] !== (i == 2)) begin errors++; $display("[TB] FAIL pat_last dut%0d beat%0d: got %b expected %b", d, i, ol[d], (i == 2)); end
            end
            tick();
        end
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("[TB] FAIL pat_done dut%0d: got %b expected 0", d, ov[d]); end
        end
    endtask

    task automatic test_back_to_back();
        int exp_code [2] = '{0, 7};
        drive(1'b1, 8'h01, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b1, 8'h80, 1'b1);
            else        drive(1'b0, 8'h00, 1'b1);
            #1;
            sample();
            for (int d = 0; d < 2; d++) begin
                checks++; if (ov[d] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid dut%0d beat%0d: got %b expected 1", d, i, ov[d]); end
                checks++; if (oc[d] !== 3'(exp_code[i])) begin errors++; $display("[TB] FAIL b2b_code dut%0d beat%0d: got %0d expected %0d", d, i, oc[d], exp_code[i]); end
                checks++; if (ol[d] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_last dut%0d beat%0d: got %b expected 1", d, i, ol[d]); end
                checks++; if (ir[d] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready dut%0d beat%0d: got %b expected 1", d, i, ir[d]); end
            end
            tick();
        end
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done dut%0d: got %b expected 0", d, ov[d]); end
        end
    endtask

    task automatic test_backpressure();
        logic rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int exp_code [2][6] = '{'{0, 1, 1, 1, 2, 3}, '{3, 2, 2, 2, 1, 0}};
        drive(1'b1, 8'h0F, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, rdy[i]);
            #1;
            sample();
            for (int d = 0; d < 2; d++) begin
                checks++; if (ov[d] !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid dut%0d beat%0d: got %b expected 1", d, i, ov[d]); end
                checks++; if (oc[d] !== 3'(exp_code[d][i])) begin errors++; $display("[TB] FAIL bp_code dut%0d beat%0d: got %0d expected %0d", d, i, oc[d], exp_code[d][i]); end
                checks++; if (ol[d] !== (i == 5)) begin errors++; $display("[TB] FAIL bp_last dut%0d beat%0d: got %b expected %b", d, i, ol[d], (i == 5)); end
                checks++; if (ir[d] !== (i == 5)) begin errors++; $display("[TB] FAIL bp_in_ready dut%0d beat%0d: got %b expected %b", d, i, ir[d], (i == 5)); end
            end
            tick();
        end
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("[TB] FAIL bp_done dut%0d: got %b expected 0", d, ov[d]); end
        end
    endtask

    task automatic test_zero();
        drive(1'b1, 8'h00, 1'b0);
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ir[d] !== 1'b1) begin errors++; $display("[TB] FAIL zero_accept dut%0d: got %b expected 1", d, ir[d]); end
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            #1;
            sample();
            for (int d = 0; d < 2; d++) begin
                checks++; if (zd[d] !== (i == 0)) begin errors++; $display("[TB] FAIL zero_pulse dut%0d cyc%0d: got %b expected %b", d, i, zd[d], (i == 0)); end
                checks++; if (ov[d] !== 1'b0) begin errors++; $display("[TB] FAIL zero_valid dut%0d cyc%0d: got %b expected 0", d, i, ov[d]); end
                checks++; if (ir[d] !== 1'b1) begin errors++; $display("[TB] FAIL zero_in_ready dut%0d cyc%0d: got %b expected 1", d, i, ir[d]); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_emit();
        int exp_code [2][3] = '{'{0, 1, 2}, '{7, 6, 5}};
        drive(1'b1, 8'hFF, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            #1;
            sample();
            for (int d = 0; d < 2; d++) begin
                checks++; if (oc[d] !== 3'(exp_code[d][i]) || ov[d] !== 1'b1) begin errors++; $display("[TB] FAIL mid_code dut%0d beat%0d: got %b/%0d expected 1/%0d", d, i, ov[d], oc[d], exp_code[d][i]); end
            end
            if (i < 2) tick();
        end
        rst_n = 1'b0;
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid dut%0d: got %b expected 0", d, ov[d]); end
            checks++; if (ir[d] !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready dut%0d: got %b expected 0", d, ir[d]); end
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            sample();
            for (int d = 0; d < 2; d++) begin
                checks++; if (ov[d] !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale dut%0d cyc%0d: got %b expected 0", d, i, ov[d]); end
                checks++; if (ir[d] !== 1'b1) begin errors++; $display("[TB] FAIL mid_idle_ready dut%0d cyc%0d: got %b expected 1", d, i, ir[d]); end
            end
        end
    endtask

    // Reference: each vector becomes an ordered list of {last, code} beats.
    task automatic test_random();
        logic [7:0] vecs [$];
        logic [3:0] q0 [$];
        logic [3:0] q1 [$];
        logic [3:0] front;
        int         sz;
        int         idx = 0;
        int         cyc = 0;
        bit         exp_zd = 1'b0;
        logic       rdy, v, exp_ir, acc_in;
        logic [7:0] data;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: vecs.push_back(8'h00);
                1: vecs.push_back(8'hFF);
                default: vecs.push_back(8'($urandom));
            endcase
        end
        while ((idx < vecs.size() || q0.size() != 0) && cyc < 4000) begin
            rdy  = ($urandom_range(0, 3) != 0);
            v    = (idx < vecs.size()) && ($urandom_range(0, 4) != 0 || q0.size() != 0);
            data = v ? vecs[idx] : 8'($urandom);
            drive(v, data, rdy);
            #1;
            sample();
            exp_ir = (q0.size() == 0) || (q0.size() == 1 && rdy);
            for (int d = 0; d < 2; d++) begin
                sz = (d == 0) ? q0.size() : q1.size();
                checks++; if (ov[d] !== (sz != 0)) begin errors++; $display("[TB] FAIL rnd_valid dut%0d cyc%0d: got %b expected %b", d, cyc, ov[d], (sz != 0)); end
                if (sz != 0) begin
                    front = (d == 0) ? q0[0] : q1[0];
                    checks++; if (oc[d] !== front[2:0]) begin errors++; $display("[TB] FAIL rnd_code dut%0d cyc%0d: got %0d expected %0d", d, cyc, oc[d], front[2:0]); end
                    checks++; if (ol[d] !== front[3]) begin errors++; $display("[TB] FAIL rnd_last dut%0d cyc%0d: got %b expected %b", d, cyc, ol[d], front[3]); end
                end
                checks++; if (ir[d] !== exp_ir) begin errors++; $display("[TB] FAIL rnd_in_ready dut%0d cyc%0d: got %b expected %b", d, cyc, ir[d], exp_ir); end
                checks++; if (zd[d] !== exp_zd) begin errors++; $display("[TB] FAIL rnd_zero_drop dut%0d cyc%0d: got %b expected %b", d, cyc, zd[d], exp_zd); end
            end
            acc_in = v && exp_ir;
            if (q0.size() != 0 && rdy) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            exp_zd = acc_in && (data == 8'h00);
            if (acc_in) begin
                int pc = $countones(data);
                int n0 = 0;
                int n1 = 0;
                for (int k = 0; k < 8; k++) begin
                    if (data[k]) begin n0++; q0.push_back({(n0 == pc), 3'(k)}); end
                    if (data[7 - k]) begin n1++; q1.push_back({(n1 == pc), 3'(7 - k)}); end
                end
                idx++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (idx < vecs.size() || q0.size() != 0) begin
            errors++;
            $display("[TB] FAIL rnd_timeout: got %0d vectors sent expected %0d", idx, vecs.size());
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_back_to_back();
        test_backpressure();
        test_zero();
        test_reset_mid_emit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
